// File: rtl/fir_pkg.sv
// Shared types and constants for the 17-tap FIR datapath and its output stage.
package fir_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned ACC_W    = 33;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

endpackage

// File: rtl/fir_out_requant_if.sv
// Valid/ready sample stream leaving the requantiser towards downstream consumers.
interface fir_out_requant_if;
  import fir_pkg::*;

  sample_t out_data;
  logic    out_valid;
  logic    out_ready;

  modport master (output out_data, output out_valid, input  out_ready);
  modport slave  (input  out_data, input  out_valid, output out_ready);

endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head holds its last popped value while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_last;
  logic             w_rd;
  logic             w_wr;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd    = i_pop & ~o_empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_wr    = i_push & (~o_full | w_rd);

  // Memory is never read while empty, so r_last keeps the output stable and zero after reset.
  assign o_head  = o_empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_last   <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        r_last   <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/fir_out_requant.sv
// Rounds/saturates the FIR accumulator to a 16-bit sample and buffers it behind valid/ready,
// tracking saturation and samples dropped while the consumer stalls.
module fir_out_requant
  import fir_pkg::*;
#(
  parameter int unsigned SHIFT = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  acc_t                   in_data,
  input  logic                   in_valid,
  input  logic                   sat_clr,
  output logic                   sat_flag,
  output logic [15:0]            drop_cnt,
  fir_out_requant_if.master      m_out
);

  localparam int unsigned EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] ROUND_BIAS = EXT_W'(1) << (SHIFT - 1);
  localparam logic signed [EXT_W-1:0] SAT_HI =
    {{(EXT_W-SAMPLE_W){SAMPLE_MAX[SAMPLE_W-1]}}, SAMPLE_MAX};
  localparam logic signed [EXT_W-1:0] SAT_LO =
    {{(EXT_W-SAMPLE_W){SAMPLE_MIN[SAMPLE_W-1]}}, SAMPLE_MIN};

  logic signed [EXT_W-1:0] w_ext;
  logic signed [EXT_W-1:0] w_rnd;
  logic signed [EXT_W-1:0] w_shr;
  sample_t                 w_clamped;
  logic                    w_sat;

  logic    r_st_valid;
  sample_t r_st_data;
  logic    r_st_sat;

  sample_t     w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_drop;
  logic        w_write;
  logic        r_sat_flag;
  logic [15:0] r_drop_cnt;

  // Round half up: bias by half an LSB of the result, then arithmetic shift.
  always_comb begin
    w_ext     = {in_data[ACC_W-1], in_data};
    w_rnd     = w_ext + ROUND_BIAS;
    w_shr     = w_rnd >>> SHIFT;
    w_sat     = 1'b0;
    w_clamped = w_shr[SAMPLE_W-1:0];
    if (w_shr > SAT_HI) begin
      w_sat     = 1'b1;
      w_clamped = SAMPLE_MAX;
    end else if (w_shr < SAT_LO) begin
      w_sat     = 1'b1;
      w_clamped = SAMPLE_MIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st_valid <= 1'b0;
      r_st_data  <= '0;
      r_st_sat   <= 1'b0;
    end else begin
      r_st_valid <= in_valid;
      if (in_valid) begin
        r_st_data <= w_clamped;
        r_st_sat  <= w_sat;
      end
    end
  end

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_st_valid),
    .i_data  (r_st_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign m_out.out_valid = ~w_empty;
  assign m_out.out_data  = w_head;
  assign w_pop           = ~w_empty & m_out.out_ready;
  assign w_drop          = r_st_valid & w_full & ~w_pop;
  assign w_write         = r_st_valid & ~w_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
      r_sat_flag <= 1'b0;
    end else begin
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_write && r_st_sat) begin
        r_sat_flag <= 1'b1;
      end else if (sat_clr) begin
        r_sat_flag <= 1'b0;
      end
    end
  end

  assign sat_flag = r_sat_flag;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_fir_out_requant.sv
// Self-checking bench for fir_out_requant: directed tables, corner sequences and random traffic
// against a queue-based reference model.
module tb_fir_out_requant;
  import fir_pkg::*;

  localparam int unsigned SHIFT = 16;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  acc_t        in_data;
  logic        in_valid;
  logic        sat_clr;
  logic        sat_flag;
  logic [15:0] drop_cnt;

  fir_out_requant_if u_if ();

  fir_out_requant #(
    .SHIFT (SHIFT),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .sat_clr  (sat_clr),
    .sat_flag (sat_flag),
    .drop_cnt (drop_cnt),
    .m_out    (u_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  sample_t mq[$];
  sample_t m_last;
  bit      m_stv;
  bit      m_sts;
  sample_t m_std;
  int      m_drop;
  bit      m_sat;

  typedef struct {
    longint din;
    longint dout;
    bit     sat;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void golden(input longint x, output sample_t y, output bit sat);
    longint d;
    longint num;
    longint q;
    d   = longint'(1) << SHIFT;
    num = x + d / 2;
    q   = num / d;
    if ((num % d) != 0 && num < 0) q = q - 1;
    sat = 1'b1;
    if (q > 32767) y = 16'sh7FFF;
    else if (q < -32768) y = 16'sh8000;
    else begin
      y   = sample_t'(q);
      sat = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_last = '0;
    m_stv  = 1'b0;
    m_sts  = 1'b0;
    m_std  = '0;
    m_drop = 0;
    m_sat  = 1'b0;
  endfunction

  task automatic check_model();
    chk("out_valid", longint'(u_if.out_valid), longint'(mq.size() > 0));
    chk("out_data", longint'(u_if.out_data), (mq.size() > 0) ? longint'(mq[0]) : longint'(m_last));
    chk("sat_flag", longint'(sat_flag), longint'(m_sat));
    chk("drop_cnt", longint'(drop_cnt), longint'(m_drop));
  endtask

  // Drive one cycle's inputs, advance the model across the edge and compare.
  task automatic tick(input bit iv, input longint d, input bit rdy, input bit clr);
    bit pop;
    bit acc;
    in_valid       = iv;
    in_data        = d[32:0];
    u_if.out_ready = rdy;
    sat_clr        = clr;
    @(posedge clk);
    pop = (mq.size() > 0) && rdy;
    acc = m_stv && ((mq.size() < DEPTH) || pop);
    if (pop) m_last = mq.pop_front();
    if (acc) mq.push_back(m_std);
    else if (m_stv && m_drop < 65535) m_drop++;
    if (acc && m_sts) m_sat = 1'b1;
    else if (clr) m_sat = 1'b0;
    m_stv = iv;
    if (iv) golden(d, m_std, m_sts);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    longint     v;
    logic [63:0] t;
    acc_t       a;

    vt[0] = '{din: 64'sd6586368,     dout: 101,    sat: 1'b0};
    vt[1] = '{din: -64'sd98304,      dout: -1,     sat: 1'b0};
    vt[2] = '{din: 64'sd65535,       dout: 1,      sat: 1'b0};
    vt[3] = '{din: 64'sd32767,       dout: 0,      sat: 1'b0};
    vt[4] = '{din: 64'sd2147483648,  dout: 32767,  sat: 1'b1};
    vt[5] = '{din: -64'sd4294967296, dout: -32768, sat: 1'b1};

    in_valid       = 1'b0;
    in_data        = '0;
    sat_clr        = 1'b0;
    u_if.out_ready = 1'b0;
    rst_n          = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", longint'(u_if.out_valid), 0);
    chk("rst_out_data", longint'(u_if.out_data), 0);
    chk("rst_sat_flag", longint'(sat_flag), 0);
    chk("rst_drop_cnt", longint'(drop_cnt), 0);
    do_reset();

    // Rounding and saturation table: output valid two edges after in_valid
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, vt[i].din, 1'b1, 1'b0);
      chk("tbl_lat_not_yet", longint'(u_if.out_valid), 0);
      tick(1'b0, 0, 1'b1, 1'b0);
      chk("tbl_valid", longint'(u_if.out_valid), 1);
      chk("tbl_data", longint'(u_if.out_data), vt[i].dout);
      chk("tbl_sat", longint'(sat_flag), longint'(vt[i].sat));
      tick(1'b0, 0, 1'b1, 1'b1);
      chk("tbl_drained", longint'(u_if.out_valid), 0);
    end

    // Set beats clear when a saturating write meets sat_clr
    tick(1'b1, 64'sd2147483648, 1'b1, 1'b0);
    tick(1'b0, 0, 1'b1, 1'b0);
    chk("sat_set", longint'(sat_flag), 1);
    tick(1'b1, 64'sd2147483648, 1'b1, 1'b0);
    tick(1'b0, 0, 1'b1, 1'b1);
    chk("sat_set_wins", longint'(sat_flag), 1);
    tick(1'b0, 0, 1'b1, 1'b1);
    chk("sat_clr_alone", longint'(sat_flag), 0);

    // Backpressure: 7 samples into a 4-deep FIFO
    for (int k = 1; k <= 7; k++) tick(1'b1, longint'(k) << 16, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b0, 1'b0);
    chk("bp_drop_cnt", longint'(drop_cnt), 3);
    chk("bp_valid", longint'(u_if.out_valid), 1);
    chk("bp_head", longint'(u_if.out_data), 1);
    for (int k = 2; k <= 4; k++) begin
      tick(1'b0, 0, 1'b1, 1'b0);
      chk("bp_drain_data", longint'(u_if.out_data), longint'(k));
    end
    tick(1'b0, 0, 1'b1, 1'b0);
    chk("bp_empty", longint'(u_if.out_valid), 0);
    chk("bp_hold", longint'(u_if.out_data), 4);

    // Full FIFO accepts a write alongside a pop
    for (int k = 1; k <= 5; k++) tick(1'b1, longint'(k) << 16, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b1, 1'b0);
    chk("fp_no_drop", longint'(drop_cnt), 3);
    chk("fp_head", longint'(u_if.out_data), 2);
    for (int k = 3; k <= 5; k++) begin
      tick(1'b0, 0, 1'b1, 1'b0);
      chk("fp_order", longint'(u_if.out_data), longint'(k));
    end
    tick(1'b0, 0, 1'b1, 1'b0);
    chk("fp_empty", longint'(u_if.out_valid), 0);

    // Back-to-back 17-sample impulse response
    for (int k = 0; k < 17; k++) begin
      t = {$urandom(), $urandom()};
      a = t[32:0];
      tick(1'b1, longint'(a) >>> $urandom_range(0, 14), 1'b1, 1'b0);
    end
    tick(1'b0, 0, 1'b1, 1'b0);
    tick(1'b0, 0, 1'b1, 1'b0);
    chk("ir_no_drops", longint'(drop_cnt), 3);
    chk("ir_drained", longint'(u_if.out_valid), 0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      t = {$urandom(), $urandom()};
      a = t[32:0];
      v = longint'(a);
      if ($urandom_range(0, 1) == 0) v = v >>> 14;
      tick($urandom_range(0, 3) != 0, v, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset with 3 queued, sat_flag set and 2 drops
    do_reset();
    tick(1'b1, 64'sd2147483648, 1'b0, 1'b0);
    for (int k = 2; k <= 6; k++) tick(1'b1, longint'(k) << 16, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b1, 1'b0);
    chk("mr_pre_drop", longint'(drop_cnt), 2);
    chk("mr_pre_sat", longint'(sat_flag), 1);
    chk("mr_pre_head", longint'(u_if.out_data), 2);
    u_if.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mr_async_valid", longint'(u_if.out_valid), 0);
    chk("mr_async_data", longint'(u_if.out_data), 0);
    chk("mr_async_sat", longint'(sat_flag), 0);
    chk("mr_async_drop", longint'(drop_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b1, 64'sd7 << 16, 1'b1, 1'b0);
    chk("mr_lat_not_yet", longint'(u_if.out_valid), 0);
    tick(1'b0, 0, 1'b1, 1'b0);
    chk("mr_post_valid", longint'(u_if.out_valid), 1);
    chk("mr_post_data", longint'(u_if.out_data), 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_out_requant.md
# fir_out_requant

Output-side companion to the 17-tap transposed FIR filter. Accepts the filter's 33-bit full-precision result stream (data + valid, no backpressure), rounds and saturates it back to a 16-bit sample, and buffers it in a small FIFO behind a valid/ready interface for downstream consumers (DAC packer, UART dump, decimator). It also counts samples dropped because the downstream stalled and flags saturation.

## Interface
- `SHIFT`, default 16: right-shift applied to the accumulator; coefficients are Q1.16. Legal range 1..17.
- `DEPTH`, default 4: FIFO depth in samples, power of two, at least 2.
- `clk`  in  1  clock; all logic on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_data`  in  33  signed filter result.
- `in_valid`  in  1  `in_data` is valid this cycle; no ready is returned.
- `out_data`  out  16  signed rounded/saturated sample, FIFO head.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `sat_clr`  in  1  synchronous clear of `sat_flag`.
- `sat_flag`  out  1  sticky; set when any accepted sample saturated.
- `drop_cnt`  out  16  saturating count of samples dropped on FIFO full.

## Operation
- Stage 1, registered: on `in_valid`, compute `s = (sign-extend-to-34(in_data) + 2^(SHIFT-1)) >>> SHIFT`, i.e. round half up with an arithmetic shift. Clamp `s` to [-32768, 32767] and register the clamped value with `st_valid` and `st_sat`. When `in_valid`=0, `st_valid` is 0.
- Stage 2, FIFO: when `st_valid`=1, write to the FIFO if not full. The write is also accepted when full and a pop occurs in the same cycle.
- Otherwise the sample is dropped and `drop_cnt` increments, saturating at 0xFFFF.
- `sat_flag` sets on any written sample with `st_sat`=1. A dropped sample never sets `sat_flag`.
- `sat_clr` clears `sat_flag`. If a set and a clear occur in the same cycle, the set wins.
- Output is first-word-fall-through: `out_data` is the FIFO head, and `out_valid` = not empty. A pop occurs on `out_valid & out_ready`.
- `out_data` holds when `out_valid`=0 and is 0 after reset.
- Pointers are log2(DEPTH)+1 bits wide. Empty when the pointers are equal. Full when the MSBs differ and the rest of the bits are equal. Pointers wrap naturally.
- Reset, asynchronous at any time including mid-burst: `out_valid`=0, `out_data`=0, `sat_flag`=0, `drop_cnt`=0, `st_valid`=0. FIFO contents are discarded.

## Timing
- Latency from `in_valid` to `out_valid` is 2 cycles with the FIFO empty. A sample presented at edge N is in stage 1 after N and readable after N+1.
- Sustained throughput is 1 sample per cycle when `out_ready`=1.
- A pop at edge M presents the next head after M.
- A pop on an empty FIFO is impossible, because `out_valid`=0.
- With simultaneous push and pop on an empty FIFO, only the push is effective.
- `drop_cnt` updates 1 cycle after the dropped sample's stage-1 cycle.
- `sat_flag` rises on the same edge as the FIFO write.

## Structure
- Shared package `fir_pkg` holds:
  - `SAMPLE_W`=16, `ACC_W`=33
  - `SAMPLE_MAX`/`SAMPLE_MIN` constants
  - typedef `sample_t` (signed 16) and `acc_t` (signed 33), which the filter also uses.
- One sub-module `sync_fifo` (parameters WIDTH, DEPTH) with push/pop/full/empty and FWFT head output.
- Rounding, saturation and the counters stay in the top.

## Test plan
- Rounding, SHIFT=16:
  - `in_data`=6586368 (100.5·2^16) -> `out_data`=101.
  - `in_data`=-98304 (-1.5·2^16) -> `out_data`=-1.
  - `in_data`=65535 -> 1.
  - `in_data`=32767 -> 0.
  - In all four cases `sat_flag` stays 0 and `out_valid` rises 2 cycles after `in_valid`.
- Saturation:
  - `in_data`=2^31 -> 32767 with `sat_flag`=1.
  - `in_data`=-2^32 -> -32768.
  - Pulse `sat_clr` together with a new saturating sample -> `sat_flag` stays 1.
  - `sat_clr` alone -> 0.
- Backpressure: `out_ready`=0, stream 7 consecutive valid samples 1..7 (each ·2^16), DEPTH=4.
  - FIFO holds 1..4 and `drop_cnt`=3.
  - Then `out_ready`=1 -> outputs 1,2,3,4 on consecutive cycles, then `out_valid`=0.
- Full with simultaneous pop: fill to 4, then push 5 in the same cycle as a pop -> no drop, and the output order is 1..5.
- Continuous stream: 17-sample filter impulse response, `out_ready`=1 -> 17 outputs back-to-back, each matching the golden rounding of its input, with zero drops.
- Reset mid-operation: assert `rst_n`=0 with 3 samples queued, `sat_flag`=1 and `drop_cnt`=2.
  - All outputs go to 0 immediately, without waiting for a clock.
  - After release, a new sample appears 2 cycles after its `in_valid`.
